uart_instr_loader: RTL and testbench
====================================

// Module: uart_instr_loader
// PURPOSE
//  Parametrised UART instruction loader and buffer for the CPU front end.
//  Receives 8N1 bytes on i_rx, packs them into INSTR_WIDTH-bit words (configurable byte order) and writes them to an
//  internal DEPTH-entry store. Exposes a synchronous read port for instruction fetch.
//  Flags load completion after an idle timeout on the line, and supports re-loading without a global reset.
// PARAMETERS
//  CLKS_PER_BIT   868  i_clk cycles per UART bit (100 MHz / 115200 baud)
//  INSTR_WIDTH    16   word width in bits; must be a multiple of 8, range 8..64
//  DEPTH          256  number of words in the store
//  ADDR_W         8    address width; DEPTH <= 2**ADDR_W
//  BIG_ENDIAN     1    1: first byte -> MSB of word; 0: first byte -> LSB
//  IDLE_BITS      32   idle bit-times on i_rx that end a load
// PORTS
//  i_clk           in   1            system clock (sole clock)
//  i_rst           in   1            asynchronous, active-high reset
//  i_rx            in   1            UART serial input, idle high, asynchronous to i_clk
//  i_reload        in   1            1-cycle pulse: clear load state and accept a new program
//  i_rd_addr       in   ADDR_W       instruction read address
//  o_rd_data       out  INSTR_WIDTH  registered read data
//  o_word_cnt      out  ADDR_W+1     number of words committed this load
//  o_load_done     out  1            load finished (sticky until i_reload/reset)
//  o_frame_err     out  1            sticky: a stop bit sampled low
//  o_overflow      out  1            sticky: a word arrived with the store full
//  o_partial       out  1            sticky: timeout hit with an incomplete word pending
// BEHAVIOUR
//  Reset: all outputs 0, RX FSM in IDLE, write pointer 0, byte counter 0. Store contents are not reset.
//  i_rx passes through a 2-FF synchroniser. All sampling uses the synchronised value.
//  RX FSM:
//   - IDLE -> START on a falling edge.
//   - START: at CLKS_PER_BIT/2, if rx=0 -> DATA, else -> IDLE (glitch rejected).
//   - DATA: 8 samples, each CLKS_PER_BIT apart, LSB first.
//   - STOP: sample after CLKS_PER_BIT. If rx=1, emit byte_valid for 1 cycle; if rx=0, set o_frame_err and drop the byte.
//   - Always -> IDLE after STOP.
//  Packing:
//   - Bytes shift into a word register; byte index counts 0..INSTR_WIDTH/8-1.
//   - On the last byte the word commits the next cycle: mem[wr_ptr] <= word, wr_ptr++, o_word_cnt++.
//  Full: if wr_ptr == DEPTH, the completed word is discarded and o_overflow=1. o_word_cnt saturates at DEPTH.
//  Timeout:
//   - Idle counter runs only in IDLE once >=1 byte has been accepted this load.
//   - It is cleared by any falling edge.
//   - After IDLE_BITS*CLKS_PER_BIT cycles: o_load_done=1. If the byte index != 0, the partial word is discarded
//     and o_partial=1.
//  While o_load_done=1, received bytes are ignored (FSM still runs, no commits, no flag changes).
//  i_reload clears wr_ptr, byte index, o_word_cnt, o_load_done, all sticky flags, the idle counter, and the RX FSM
//   (returns to IDLE; an in-flight byte is lost). Reload wins over a same-cycle byte commit.
//  Read: o_rd_data updates 1 cycle after i_rd_addr:
//   - mem[i_rd_addr] if i_rd_addr < o_word_cnt, else 0.
//   - Read and write to the same address in the same cycle returns the old (pre-write) data.
//  Reset asserted mid-frame aborts the frame and all load state. Reads are valid again from the cycle after deassert.
// TESTING (100 MHz i_clk, bit time 8680 ns, defaults unless stated)
//  1 Send A5 5A 3C 2B, wait 40 bit-times -> o_word_cnt=2, o_load_done=1; addr 0 -> A55A, addr 1 -> 3C2B
//    (1 cycle latency), addr 2 -> 0000.
//  2 BIG_ENDIAN=0, INSTR_WIDTH=32, send 11 22 33 44 -> mem[0]=44332211, o_word_cnt=1.
//  3 Send 0x10 with stop bit driven 0, then A5 5A -> o_frame_err=1, o_word_cnt=1, mem[0]=A55A.
//  4 DEPTH=4, send 10 bytes of 0x10 -> o_word_cnt=4, o_overflow=1, every addr 0..3 reads 1010.
//  5 Send A5 5A 3C, then idle -> o_word_cnt=1, o_partial=1, o_load_done=1.
//  6 After case 1, pulse i_reload, send 12 34 -> o_word_cnt=1, addr 0 -> 1234. Assert i_rst mid-byte
//    -> all outputs 0 within 1 cycle.

Source files
------------

// File: rtl/uart_instr_loader.sv
// UART instruction loader: receives 8N1 bytes, packs them into instruction words
// and stores them in a program buffer exposed through a registered read port.
module uart_instr_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int INSTR_WIDTH  = 16,
   parameter int DEPTH        = 256,
   parameter int ADDR_W       = 8,
   parameter bit BIG_ENDIAN   = 1'b1,
   parameter int IDLE_BITS    = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rx,
   input  logic                   i_reload,
   input  logic [ADDR_W-1:0]      i_rd_addr,
   output logic [INSTR_WIDTH-1:0] o_rd_data,
   output logic [ADDR_W:0]        o_word_cnt,
   output logic                   o_load_done,
   output logic                   o_frame_err,
   output logic                   o_overflow,
   output logic                   o_partial
);
   localparam int BYTES       = INSTR_WIDTH / 8;
   localparam int BIDX_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int MEM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W       = $clog2(CLKS_PER_BIT + 1);
   localparam int IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
   localparam int IDLE_W      = $clog2(IDLE_CYCLES + 1);

   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTES - 1);
   localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

   rx_state_t              state, state_next;
   logic                   rx_meta, rx_sync, rx_prev;
   logic                   rx_fall;
   logic [CNT_W-1:0]       clk_cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shift_reg;
   logic                   bit_tick, byte_valid, stop_bad, accept;
   logic [INSTR_WIDTH-1:0] word_reg, word_next;
   logic [BIDX_W-1:0]      byte_idx;
   logic                   commit_pending, bytes_seen, mem_we;
   logic [ADDR_W:0]        wr_ptr;
   logic [IDLE_W-1:0]      idle_cnt;
   logic [INSTR_WIDTH-1:0] mem [DEPTH];

   // rx_prev lets edge detection work on the already-synchronised line
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign rx_fall = rx_prev & ~rx_sync;

   always_comb begin
      state_next = state;
      bit_tick   = 1'b0;
      byte_valid = 1'b0;
      stop_bad   = 1'b0;
      unique case (state)
         S_IDLE:  if (rx_fall) state_next = S_START;
         S_START: if (clk_cnt == HALF_LAST) state_next = rx_sync ? S_IDLE : S_DATA;
         S_DATA:  if (clk_cnt == BIT_LAST) begin
                     bit_tick = 1'b1;
                     if (bit_idx == 3'd7) state_next = S_STOP;
                  end
         S_STOP:  if (clk_cnt == BIT_LAST) begin
                     state_next = S_IDLE;
                     byte_valid = rx_sync;
                     stop_bad   = ~rx_sync;
                  end
         default: state_next = S_IDLE;
      endcase
      if (i_reload) state_next = S_IDLE;
   end

   // The bit timer restarts on every state change and every data sample
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         state <= state_next;
         if (state == S_IDLE || state_next != state || bit_tick) clk_cnt <= '0;
         else clk_cnt <= clk_cnt + 1'b1;
         if (state == S_IDLE) bit_idx <= '0;
         else if (bit_tick) bit_idx <= bit_idx + 1'b1;
         if (bit_tick) shift_reg <= {rx_sync, shift_reg[7:1]};
      end
   end

   assign accept = byte_valid & ~o_load_done & ~i_reload;

   always_comb begin
      if (BIG_ENDIAN) word_next = (word_reg << 8) | INSTR_WIDTH'(shift_reg);
      else            word_next = (word_reg >> 8) | (INSTR_WIDTH'(shift_reg) << (INSTR_WIDTH - 8));
   end

   // Load bookkeeping; reload takes priority over any commit in the same cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         word_reg       <= '0;
         byte_idx       <= '0;
         commit_pending <= 1'b0;
         bytes_seen     <= 1'b0;
         wr_ptr         <= '0;
         idle_cnt       <= '0;
         o_load_done    <= 1'b0;
         o_frame_err    <= 1'b0;
         o_overflow     <= 1'b0;
         o_partial      <= 1'b0;
      end else if (i_reload) begin
         byte_idx       <= '0;
         commit_pending <= 1'b0;
         bytes_seen     <= 1'b0;
         wr_ptr         <= '0;
         idle_cnt       <= '0;
         o_load_done    <= 1'b0;
         o_frame_err    <= 1'b0;
         o_overflow     <= 1'b0;
         o_partial      <= 1'b0;
      end else begin
         commit_pending <= 1'b0;
         if (commit_pending) begin
            if (wr_ptr == DEPTH_V) o_overflow <= 1'b1;
            else wr_ptr <= wr_ptr + 1'b1;
         end
         if (stop_bad && !o_load_done) o_frame_err <= 1'b1;
         if (accept) begin
            word_reg   <= word_next;
            bytes_seen <= 1'b1;
            if (byte_idx == BIDX_LAST) begin
               byte_idx       <= '0;
               commit_pending <= 1'b1;
            end else begin
               byte_idx <= byte_idx + 1'b1;
            end
         end
         if (rx_fall) begin
            idle_cnt <= '0;
         end else if (state == S_IDLE && bytes_seen && !o_load_done) begin
            if (idle_cnt == IDLE_LAST) begin
               idle_cnt    <= '0;
               o_load_done <= 1'b1;
               if (byte_idx != '0) begin
                  o_partial <= 1'b1;
                  byte_idx  <= '0;
               end
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end
   end

   assign mem_we = commit_pending & ~i_reload & (wr_ptr != DEPTH_V);

   always_ff @(posedge i_clk) begin
      if (mem_we) mem[wr_ptr[MEM_AW-1:0]] <= word_reg;
   end

   // Addresses beyond the committed words read as zero, hiding stale contents
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_rd_data <= '0;
      else if ({1'b0, i_rd_addr} < wr_ptr) o_rd_data <= mem[i_rd_addr[MEM_AW-1:0]];
      else o_rd_data <= '0;
   end

   assign o_word_cnt = wr_ptr;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Bench for uart_instr_loader: three instances (default 16-bit big-endian, 32-bit
// little-endian, 4-deep store) driven with directed UART frames.
module tb_uart_instr_loader;
   localparam int CPB       = 16;
   localparam int IDLE_BITS = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        reload;
   logic        rx [3];
   logic [7:0]  rd_addr [3];
   logic [15:0] rd0, rd2;
   logic [31:0] rd1;
   logic [8:0]  cnt [3];
   logic        done [3], ferr [3], ovf [3], part [3];

   int checks_total  = 0;
   int checks_passed = 0;

   logic [15:0] m_mem [256];
   int          m_cnt;
   bit          m_done, m_ferr, m_ovf, m_part;
   bit          check_en = 1'b0;
   bit          prev_valid = 1'b0;
   logic [7:0]  prev_addr = 8'h00;

   always #5 clk = ~clk;

   uart_instr_loader #(.CLKS_PER_BIT(CPB), .INSTR_WIDTH(16), .DEPTH(256), .ADDR_W(8),
                       .BIG_ENDIAN(1'b1), .IDLE_BITS(IDLE_BITS)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_rx(rx[0]), .i_reload(reload), .i_rd_addr(rd_addr[0]),
      .o_rd_data(rd0), .o_word_cnt(cnt[0]), .o_load_done(done[0]), .o_frame_err(ferr[0]),
      .o_overflow(ovf[0]), .o_partial(part[0]));

   uart_instr_loader #(.CLKS_PER_BIT(CPB), .INSTR_WIDTH(32), .DEPTH(256), .ADDR_W(8),
                       .BIG_ENDIAN(1'b0), .IDLE_BITS(IDLE_BITS)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_rx(rx[1]), .i_reload(reload), .i_rd_addr(rd_addr[1]),
      .o_rd_data(rd1), .o_word_cnt(cnt[1]), .o_load_done(done[1]), .o_frame_err(ferr[1]),
      .o_overflow(ovf[1]), .o_partial(part[1]));

   uart_instr_loader #(.CLKS_PER_BIT(CPB), .INSTR_WIDTH(16), .DEPTH(4), .ADDR_W(8),
                       .BIG_ENDIAN(1'b1), .IDLE_BITS(IDLE_BITS)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_rx(rx[2]), .i_reload(reload), .i_rd_addr(rd_addr[2]),
      .o_rd_data(rd2), .o_word_cnt(cnt[2]), .o_load_done(done[2]), .o_frame_err(ferr[2]),
      .o_overflow(ovf[2]), .o_partial(part[2]));

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Transaction-level model of the default instance: whole loads, not cycles
   task automatic model_clear();
      m_cnt  = 0;
      m_done = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
      m_part = 1'b0;
   endtask

   task automatic model_load(input logic [7:0] bytes[$], input bit ok[$]);
      logic [7:0] pend[$];
      for (int i = 0; i < bytes.size(); i++) begin
         if (!ok[i]) begin
            m_ferr = 1'b1;
         end else begin
            pend.push_back(bytes[i]);
            if (pend.size() == 2) begin
               if (m_cnt < 256) begin
                  m_mem[m_cnt] = {pend[0], pend[1]};
                  m_cnt++;
               end else begin
                  m_ovf = 1'b1;
               end
               pend.delete();
            end
         end
      end
      if (pend.size() != 0) m_part = 1'b1;
      m_done = 1'b1;
   endtask

   function automatic logic [15:0] model_read(input logic [7:0] addr);
      return (int'(addr) < m_cnt) ? m_mem[addr] : 16'h0000;
   endfunction

   always @(posedge clk) begin
      prev_addr  <= rd_addr[0];
      prev_valid <= check_en & ~rst;
   end

   // Continuous comparison of the default instance against the model
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("cnt0", 64'(cnt[0]), 64'(m_cnt));
         checkOutput("done0", 64'(done[0]), 64'(m_done));
         checkOutput("ferr0", 64'(ferr[0]), 64'(m_ferr));
         checkOutput("ovf0", 64'(ovf[0]), 64'(m_ovf));
         checkOutput("part0", 64'(part[0]), 64'(m_part));
         if (prev_valid) checkOutput("rd0_model", 64'(rd0), 64'(model_read(prev_addr)));
      end
   end

   function automatic logic [63:0] rd_value(input int lane);
      case (lane)
         0:       return 64'(rd0);
         1:       return 64'(rd1);
         default: return 64'(rd2);
      endcase
   endfunction

   task automatic drive_bit(input int lane, input logic v);
      rx[lane] = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input int lane, input logic [7:0] b, input bit stop_ok);
      drive_bit(lane, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(lane, b[i]);
      drive_bit(lane, stop_ok);
      drive_bit(lane, 1'b1);
   endtask

   task automatic wait_done(input int lane);
      int n = 0;
      while (!done[lane] && n < 3 * IDLE_BITS * CPB) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!done[lane]) checkOutput("load_done_timeout", 64'd0, 64'd1);
   endtask

   task automatic applyStimulus(input int lane, input logic [7:0] bytes[$], input bit ok[$]);
      if (lane == 0) check_en = 1'b0;
      for (int i = 0; i < bytes.size(); i++) send_byte(lane, bytes[i], ok[i]);
      wait_done(lane);
      if (lane == 0) begin
         model_load(bytes, ok);
         check_en = 1'b1;
      end
   endtask

   task automatic do_reload();
      check_en = 1'b0;
      reload   = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      model_clear();
      check_en = 1'b1;
   endtask

   task automatic read_check(input string name, input int lane, input logic [7:0] addr, input logic [63:0] expected);
      rd_addr[lane] = addr;
      @(posedge clk);
      #1;
      checkOutput(name, rd_value(lane), expected);
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      reload  = 1'b0;
      rx      = '{1'b1, 1'b1, 1'b1};
      rd_addr = '{8'h00, 8'h00, 8'h00};
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      for (int l = 0; l < 3; l++) begin
         checkOutput("reset_cnt", 64'(cnt[l]), 64'd0);
         checkOutput("reset_done", 64'(done[l]), 64'd0);
         checkOutput("reset_flags", 64'({ferr[l], ovf[l], part[l]}), 64'd0);
         checkOutput("reset_rd", rd_value(l), 64'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_en = 1'b1;

      $display("[TB] basic big-endian load");
      applyStimulus(0, '{8'hA5, 8'h5A, 8'h3C, 8'h2B}, '{1, 1, 1, 1});
      checkOutput("c1_cnt", 64'(cnt[0]), 64'd2);
      checkOutput("c1_done", 64'(done[0]), 64'd1);
      read_check("c1_addr0", 0, 8'd0, 64'hA55A);
      read_check("c1_addr1", 0, 8'd1, 64'h3C2B);
      read_check("c1_addr2", 0, 8'd2, 64'h0000);
      read_check("c1_addr0_again", 0, 8'd0, 64'hA55A);

      $display("[TB] little-endian 32-bit load");
      applyStimulus(1, '{8'h11, 8'h22, 8'h33, 8'h44}, '{1, 1, 1, 1});
      checkOutput("c2_cnt", 64'(cnt[1]), 64'd1);
      checkOutput("c2_flags", 64'({ferr[1], ovf[1], part[1]}), 64'd0);
      read_check("c2_addr0", 1, 8'd0, 64'h44332211);
      read_check("c2_addr1", 1, 8'd1, 64'h0);

      $display("[TB] overflow on 4-deep store");
      applyStimulus(2, '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10},
                    '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1});
      checkOutput("c4_cnt", 64'(cnt[2]), 64'd4);
      checkOutput("c4_ovf", 64'(ovf[2]), 64'd1);
      checkOutput("c4_done", 64'(done[2]), 64'd1);
      checkOutput("c4_part_ferr", 64'({part[2], ferr[2]}), 64'd0);
      for (int a = 0; a < 4; a++) read_check("c4_addr", 2, 8'(a), 64'h1010);

      $display("[TB] frame error then good word");
      do_reload();
      applyStimulus(0, '{8'h10, 8'hA5, 8'h5A}, '{0, 1, 1});
      checkOutput("c3_ferr", 64'(ferr[0]), 64'd1);
      checkOutput("c3_cnt", 64'(cnt[0]), 64'd1);
      read_check("c3_addr0", 0, 8'd0, 64'hA55A);
      read_check("c3_addr1", 0, 8'd1, 64'h0000);

      $display("[TB] partial word on timeout");
      do_reload();
      applyStimulus(0, '{8'hA5, 8'h5A, 8'h3C}, '{1, 1, 1});
      checkOutput("c5_cnt", 64'(cnt[0]), 64'd1);
      checkOutput("c5_partial", 64'(part[0]), 64'd1);
      checkOutput("c5_done", 64'(done[0]), 64'd1);
      read_check("c5_addr1", 0, 8'd1, 64'h0000);

      $display("[TB] reload and mid-frame reset");
      do_reload();
      applyStimulus(0, '{8'h12, 8'h34}, '{1, 1});
      checkOutput("c6_cnt", 64'(cnt[0]), 64'd1);
      read_check("c6_addr0", 0, 8'd0, 64'h1234);
      check_en = 1'b0;
      rx[0] = 1'b0;
      repeat (CPB * 4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("c6_rst_cnt", 64'(cnt[0]), 64'd0);
      checkOutput("c6_rst_done", 64'(done[0]), 64'd0);
      checkOutput("c6_rst_rd", 64'(rd0), 64'd0);
      checkOutput("c6_rst_flags", 64'({ferr[0], ovf[0], part[0]}), 64'd0);
      rx[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      check_en = 1'b1;
      read_check("c6_post_rst_addr0", 0, 8'd0, 64'h0000);
      applyStimulus(0, '{8'hAB, 8'hCD}, '{1, 1});
      checkOutput("c6_recover_cnt", 64'(cnt[0]), 64'd1);
      read_check("c6_recover_addr0", 0, 8'd0, 64'hABCD);
      repeat (4) @(posedge clk);
      #1;
      check_en = 1'b0;

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
